// File: rtl/reg_bank_scheduler.sv
// -----------------------------------------------------------------------------
// reg_bank_scheduler
//
// Arbitrates write access to a bank of 8-bit time/date registers between two
// requesters: A (bus-read path) and B (user-edit path). A granted transaction
// drives the shared data bus and one bit of a one-hot load enable for one
// cycle, acknowledges the owner one cycle later, then holds off further grants
// for GAP_CYC idle cycles.
//
// Ports
//   clk       in   system clock, rising edge
//   reset     in   asynchronous active-low reset
//   req_a     in   requester A write request (level)
//   addr_a    in   requester A target register index
//   data_a    in   requester A write data
//   ack_a     out  one-cycle completion pulse to A
//   req_b     in   requester B write request (level)
//   addr_b    in   requester B target register index
//   data_b    in   requester B write data
//   ack_b     out  one-cycle completion pulse to B
//   datos     out  shared data bus to the bank, holds last loaded value
//   enable    out  one-hot load enable, bit i loads register i
//   busy      out  high from grant until the scheduler can accept again
//   addr_err  out  one-cycle pulse when the granted address is >= N_REGS
//
// Timing (all outputs registered): request sampled at edge 0, enable/datos
// valid between edges 1 and 2, ack between edges 2 and 3, next grant possible
// at edge 3+GAP_CYC.
// -----------------------------------------------------------------------------
module reg_bank_scheduler #(
   parameter int N_REGS  = 6,
   parameter int ADDR_W  = 3,
   parameter int GAP_CYC = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_a,
   input  logic [ADDR_W-1:0] addr_a,
   input  logic [7:0]        data_a,
   output logic              ack_a,
   input  logic              req_b,
   input  logic [ADDR_W-1:0] addr_b,
   input  logic [7:0]        data_b,
   output logic              ack_b,
   output logic [7:0]        datos,
   output logic [N_REGS-1:0] enable,
   output logic              busy,
   output logic              addr_err
);

   // Gap counter only has to reach GAP_CYC-1; keep at least one bit so the
   // GAP_CYC=0 build still elaborates (its GAP state is simply unreachable).
   localparam int                CNT_W     = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
   localparam logic [CNT_W-1:0]  GAP_LAST  = CNT_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
   localparam logic [ADDR_W:0]   N_REGS_L  = (ADDR_W+1)'(N_REGS);

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOAD,
      S_ACK,
      S_GAP
   } state_t;

   state_t              state,    state_nxt;
   logic                last_b,   last_b_nxt;    // 1: B won the most recent tie
   logic                gnt_b,    gnt_b_nxt;     // owner of the current transaction
   logic [ADDR_W-1:0]   lat_addr, lat_addr_nxt;
   logic [7:0]          lat_data, lat_data_nxt;
   logic [CNT_W-1:0]    gap_cnt,  gap_cnt_nxt;

   logic [7:0]          datos_nxt;
   logic [N_REGS-1:0]   enable_nxt;
   logic                ack_a_nxt, ack_b_nxt, busy_nxt, addr_err_nxt;
   logic                addr_ok;

   assign addr_ok = {1'b0, lat_addr} < N_REGS_L;

   // NOTE: every signal written here gets a default before the case statement,
   // so no path can leave one unassigned and infer a latch.
   always_comb begin
      state_nxt    = state;
      last_b_nxt   = last_b;
      gnt_b_nxt    = gnt_b;
      lat_addr_nxt = lat_addr;
      lat_data_nxt = lat_data;
      gap_cnt_nxt  = gap_cnt;
      datos_nxt    = datos;
      enable_nxt   = '0;
      ack_a_nxt    = 1'b0;
      ack_b_nxt    = 1'b0;
      addr_err_nxt = 1'b0;
      // busy clears one cycle after the FSM returns to IDLE, so the visible
      // busy window lines up with the registered enable/ack outputs.
      busy_nxt     = (state != S_IDLE);

      case (state)
         S_IDLE: begin
            if (req_a || req_b) begin
               if (req_a && req_b) begin
                  // Round-robin only on contention: the side that did not win
                  // the previous tie goes first.
                  gnt_b_nxt  = ~last_b;
                  last_b_nxt = ~last_b;
               end else begin
                  gnt_b_nxt  = req_b;
               end
               lat_addr_nxt = gnt_b_nxt ? addr_b : addr_a;
               lat_data_nxt = gnt_b_nxt ? data_b : data_a;
               busy_nxt     = 1'b1;
               state_nxt    = S_LOAD;
            end
         end

         S_LOAD: begin
            datos_nxt = lat_data;
            if (addr_ok) begin
               enable_nxt = N_REGS'(1) << lat_addr;
            end else begin
               // Out-of-range target: no register is loaded, but the
               // transaction still completes so the requester is not stuck.
               addr_err_nxt = 1'b1;
            end
            state_nxt = S_ACK;
         end

         S_ACK: begin
            ack_a_nxt = ~gnt_b;
            ack_b_nxt = gnt_b;
            if (GAP_CYC > 0) begin
               gap_cnt_nxt = '0;
               state_nxt   = S_GAP;
            end else begin
               state_nxt   = S_IDLE;
            end
         end

         S_GAP: begin
            if (gap_cnt == GAP_LAST) begin
               state_nxt = S_IDLE;
            end else begin
               gap_cnt_nxt = gap_cnt + 1'b1;
            end
         end

         default: state_nxt = S_IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values regardless of statement order.
   // NOTE: the latched address/data are reset along with the control state;
   // they are a handful of flops, and resetting them keeps X off the bus.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= S_IDLE;
         last_b   <= 1'b1;
         gnt_b    <= 1'b0;
         lat_addr <= '0;
         lat_data <= 8'h00;
         gap_cnt  <= '0;
         datos    <= 8'h00;
         enable   <= '0;
         ack_a    <= 1'b0;
         ack_b    <= 1'b0;
         busy     <= 1'b0;
         addr_err <= 1'b0;
      end else begin
         state    <= state_nxt;
         last_b   <= last_b_nxt;
         gnt_b    <= gnt_b_nxt;
         lat_addr <= lat_addr_nxt;
         lat_data <= lat_data_nxt;
         gap_cnt  <= gap_cnt_nxt;
         datos    <= datos_nxt;
         enable   <= enable_nxt;
         ack_a    <= ack_a_nxt;
         ack_b    <= ack_b_nxt;
         busy     <= busy_nxt;
         addr_err <= addr_err_nxt;
      end
   end

endmodule

// File: tb/tb_reg_bank_scheduler.sv
// -----------------------------------------------------------------------------
// tb_reg_bank_scheduler
//
// Two schedulers side by side: the default build (GAP_CYC=2) and a GAP_CYC=0
// build. Each has a transaction-level model that tracks only "cycles since the
// last grant" and derives every output from that count. A compare process
// checks all outputs of both builds on every falling edge; directed tests add
// hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_reg_bank_scheduler;

   localparam int GAP = 2;

   logic       clk;
   logic       reset;

   logic       req_a, req_b;
   logic [2:0] addr_a, addr_b;
   logic [7:0] data_a, data_b;
   logic       ack_a, ack_b, busy, addr_err;
   logic [7:0] datos;
   logic [5:0] enable;

   logic       req_a0, req_b0;
   logic [2:0] addr_a0, addr_b0;
   logic [7:0] data_a0, data_b0;
   logic       ack_a0, ack_b0, busy0, addr_err0;
   logic [7:0] datos0;
   logic [5:0] enable0;

   int checks = 0;
   int errors = 0;

   reg_bank_scheduler #(.N_REGS(6), .ADDR_W(3), .GAP_CYC(GAP)) u_dut (
      .clk(clk), .reset(reset),
      .req_a(req_a), .addr_a(addr_a), .data_a(data_a), .ack_a(ack_a),
      .req_b(req_b), .addr_b(addr_b), .data_b(data_b), .ack_b(ack_b),
      .datos(datos), .enable(enable), .busy(busy), .addr_err(addr_err)
   );

   reg_bank_scheduler #(.N_REGS(6), .ADDR_W(3), .GAP_CYC(0)) u_dut0 (
      .clk(clk), .reset(reset),
      .req_a(req_a0), .addr_a(addr_a0), .data_a(data_a0), .ack_a(ack_a0),
      .req_b(req_b0), .addr_b(addr_b0), .data_b(data_b0), .ack_b(ack_b0),
      .datos(datos0), .enable(enable0), .busy(busy0), .addr_err(addr_err0)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // ---------------------------------------------------------------- model
   // A transaction is "active" from its grant edge (since=0) until the edge
   // at which a new request may be sampled (since = 2+gap). Enable/datos show
   // at since=1, ack at since=2, busy whenever a transaction is active.
   typedef struct packed {
      logic       active;
      logic [3:0] since;
      logic       gnt_b;
      logic       last_b;
      logic [2:0] addr;
      logic [7:0] data;
      logic [7:0] datos;
   } model_t;

   model_t m2, m0;

   function automatic model_t model_reset();
      model_t r;
      r.active = 1'b0;
      r.since  = 4'd0;
      r.gnt_b  = 1'b0;
      r.last_b = 1'b1;
      r.addr   = 3'd0;
      r.data   = 8'h00;
      r.datos  = 8'h00;
      return r;
   endfunction

   function automatic model_t step(model_t s, int gap,
                                   logic ra, logic [2:0] aa, logic [7:0] da,
                                   logic rb, logic [2:0] ab, logic [7:0] db);
      model_t n;
      n = s;
      if (!s.active || s.since == 4'(2 + gap)) begin
         n.active = ra || rb;
         n.since  = 4'd0;
         if (ra && rb) begin
            n.gnt_b  = !s.last_b;
            n.last_b = !s.last_b;
         end else if (ra || rb) begin
            n.gnt_b  = rb;
         end
         if (ra || rb) begin
            n.addr = n.gnt_b ? ab : aa;
            n.data = n.gnt_b ? db : da;
         end
      end else begin
         n.since = s.since + 4'd1;
         if (n.since == 4'd1) n.datos = s.data;
      end
      return n;
   endfunction

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         m2 <= model_reset();
         m0 <= model_reset();
      end else begin
         m2 <= step(m2, GAP, req_a, addr_a, data_a, req_b, addr_b, data_b);
         m0 <= step(m0, 0, req_a0, addr_a0, data_a0, req_b0, addr_b0, data_b0);
      end
   end

   // ---------------------------------------------------------------- checking
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   task automatic cmp(input string tag, input model_t m, input logic [5:0] en,
                      input logic [7:0] dt, input logic aa, input logic ab,
                      input logic bz, input logic ae);
      logic       hit;
      logic       in_range;
      logic [5:0] e_en;
      hit      = m.active && (m.since == 4'd1);
      in_range = m.addr < 3'd6;
      e_en     = (hit && in_range) ? (6'b000001 << m.addr) : 6'b000000;
      check({tag, " enable"},   32'(en), 32'(e_en));
      check({tag, " datos"},    32'(dt), 32'(m.datos));
      check({tag, " ack_a"},    32'(aa), 32'(m.active && m.since == 4'd2 && !m.gnt_b));
      check({tag, " ack_b"},    32'(ab), 32'(m.active && m.since == 4'd2 && m.gnt_b));
      check({tag, " busy"},     32'(bz), 32'(m.active));
      check({tag, " addr_err"}, 32'(ae), 32'(hit && !in_range));
   endtask

   always @(negedge clk) begin
      cmp("gap2", m2, enable,  datos,  ack_a,  ack_b,  busy,  addr_err);
      cmp("gap0", m0, enable0, datos0, ack_a0, ack_b0, busy0, addr_err0);
   end

   // ---------------------------------------------------------------- stimulus
   logic [5:0] cen  [8];
   logic [7:0] cdat [8];
   logic       caa  [8];
   logic       cab  [8];
   logic       cbz  [8];
   logic       cae  [8];

   // Runs n falling edges after a request was driven, dropping both requests
   // right after the grant edge, and records the outputs seen at each one.
   task automatic run_capture(input int n);
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         if (k == 0) begin
            req_a = 1'b0;
            req_b = 1'b0;
         end
         cen[k]  = enable;
         cdat[k] = datos;
         caa[k]  = ack_a;
         cab[k]  = ack_b;
         cbz[k]  = busy;
         cae[k]  = addr_err;
      end
   endtask

   initial begin : stim
      int         ng;
      int         nack;
      int         nbusy;
      int         g_cyc [4];
      logic [5:0] g_en  [4];
      logic [7:0] g_dat [4];
      logic       seq   [8];
      int         ecyc  [8];

      reset  = 1'b0;
      req_a  = 1'b0; addr_a  = 3'd0; data_a  = 8'h00;
      req_b  = 1'b0; addr_b  = 3'd0; data_b  = 8'h00;
      req_a0 = 1'b0; addr_a0 = 3'd0; data_a0 = 8'h00;
      req_b0 = 1'b0; addr_b0 = 3'd0; data_b0 = 8'h00;

      // ---- reset state
      repeat (2) @(negedge clk);
      check("rst enable", 32'(enable), 32'h0);
      check("rst datos",  32'(datos),  32'h0);
      check("rst busy",   32'(busy),   32'h0);
      check("rst acks",   32'({ack_a, ack_b, addr_err}), 32'h0);
      reset = 1'b1;
      @(negedge clk);

      // ---- single A request: addr 2, F6
      req_a = 1'b1; addr_a = 3'd2; data_a = 8'hF6;
      run_capture(6);
      check("t1 busy at grant", 32'(cbz[0]), 32'h1);
      check("t1 enable",        32'(cen[1]), 32'b000100);
      check("t1 datos",         32'(cdat[1]), 32'hF6);
      check("t1 ack_a",         32'(caa[2]), 32'h1);
      check("t1 enable off",    32'(cen[2]), 32'h0);
      nbusy = 0;
      for (int k = 0; k < 6; k++) if (cbz[k]) nbusy++;
      check("t1 busy cycles",   32'(nbusy), 32'd5);

      // ---- simultaneous requests: A first, B after the gap
      req_a = 1'b1; addr_a = 3'd0; data_a = 8'h5A;
      req_b = 1'b1; addr_b = 3'd1; data_b = 8'h31;
      ng = 0;
      for (int k = 0; k < 14; k++) begin
         @(negedge clk);
         if (ack_a) req_a = 1'b0;
         if (ack_b) req_b = 1'b0;
         if (enable != 6'b0 && ng < 4) begin
            g_en[ng]  = enable;
            g_dat[ng] = datos;
            g_cyc[ng] = k;
            ng++;
         end
      end
      req_a = 1'b0; req_b = 1'b0;
      check("t2 grant count", 32'(ng), 32'd2);
      if (ng == 2) begin
         check("t2 first enable",  32'(g_en[0]),  32'b000001);
         check("t2 first datos",   32'(g_dat[0]), 32'h5A);
         check("t2 second enable", 32'(g_en[1]),  32'b000010);
         check("t2 second datos",  32'(g_dat[1]), 32'h31);
         check("t2 spacing",       32'(g_cyc[1] - g_cyc[0]), 32'd5);
      end

      // ---- both held high from a fresh reset: strict alternation A,B,A,B
      @(negedge clk); reset = 1'b0;
      @(negedge clk); reset = 1'b1;
      @(negedge clk);
      req_a = 1'b1; addr_a = 3'd3; data_a = 8'h11;
      req_b = 1'b1; addr_b = 3'd5; data_b = 8'h22;
      nack = 0;
      for (int k = 0; k < 21; k++) begin
         @(negedge clk);
         if ((ack_a || ack_b) && nack < 8) begin
            seq[nack] = ack_b;
            nack++;
         end
      end
      req_a = 1'b0; req_b = 1'b0;
      repeat (6) @(negedge clk);
      check("t3 ack count", 32'(nack), 32'd4);
      if (nack >= 4) begin
         check("t3 first is A", 32'(seq[0]), 32'h0);
         for (int i = 1; i < 4; i++)
            check("t3 alternation", 32'(seq[i] ^ seq[i-1]), 32'h1);
      end

      // ---- out-of-range address from B
      req_b = 1'b1; addr_b = 3'd7; data_b = 8'h83;
      run_capture(6);
      check("t4 no enable",     32'(cen[1]), 32'h0);
      check("t4 addr_err",      32'(cae[1]), 32'h1);
      check("t4 addr_err pre",  32'(cae[0]), 32'h0);
      check("t4 addr_err post", 32'(cae[2]), 32'h0);
      check("t4 datos",         32'(cdat[1]), 32'h83);
      check("t4 ack_b",         32'(cab[2]), 32'h1);
      check("t4 ack_a",         32'(caa[2]), 32'h0);

      // ---- reset in the middle of a load
      req_a = 1'b1; addr_a = 3'd4; data_a = 8'hD3;
      @(negedge clk);
      req_a = 1'b0;
      @(negedge clk);
      check("t5 enable before reset", 32'(enable), 32'b010000);
      check("t5 datos before reset",  32'(datos),  32'hD3);
      #2 reset = 1'b0;
      #1;
      check("t5 enable in reset", 32'(enable), 32'h0);
      check("t5 busy in reset",   32'(busy),   32'h0);
      check("t5 datos in reset",  32'(datos),  32'h0);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("t5 no ack_a", 32'(ack_a), 32'h0);
      end
      reset = 1'b1;
      @(negedge clk);
      req_a = 1'b1; addr_a = 3'd4; data_a = 8'h8D;
      run_capture(6);
      check("t5 reload enable", 32'(cen[1]), 32'b010000);
      check("t5 reload datos",  32'(cdat[1]), 32'h8D);
      check("t5 reload ack_a",  32'(caa[2]), 32'h1);

      // ---- GAP_CYC=0 build: continuous requests load every 3 cycles
      req_a0 = 1'b1; addr_a0 = 3'd1; data_a0 = 8'h44;
      ng = 0;
      for (int k = 0; k < 13; k++) begin
         @(negedge clk);
         if (enable0 != 6'b0 && ng < 8) begin
            ecyc[ng] = k;
            ng++;
         end
      end
      req_a0 = 1'b0;
      repeat (4) @(negedge clk);
      check("t6 pulse count", 32'(ng), 32'd4);
      if (ng == 4) begin
         for (int i = 1; i < 4; i++)
            check("t6 spacing", 32'(ecyc[i] - ecyc[i-1]), 32'd3);
      end

      // ---- GAP_CYC=0 build: request dropped right after grant
      req_a0 = 1'b1; addr_a0 = 3'd5; data_a0 = 8'h9C;
      @(negedge clk);
      req_a0 = 1'b0;
      @(negedge clk);
      check("t6 drop enable", 32'(enable0), 32'b100000);
      check("t6 drop datos",  32'(datos0),  32'h9C);
      @(negedge clk);
      check("t6 drop ack_a",  32'(ack_a0),  32'h1);
      repeat (3) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
